imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder on the fetch-side IO interface: accepts a single outstanding word-read request (`io_reqValid`/`io_addr`), waits a fixed programmable latency, then returns the instruction word with a one-cycle `io_respValid` pulse. It sits between the fetch unit's IO port and a word-addressed on-chip instruction array, and it is the responder counterpart of the fetch unit's request/wait handshake. A backdoor write port preloads program images in simulation and during boot.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; power of two, ≥ 4.
- `LATENCY`, 2: cycles from request acceptance to response; legal range 1..15.
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `io_reqValid` in 1: fetch request valid.
- `io_addr` in 32: byte address of the requested instruction.
- `io_respValid` out 1: one-cycle response pulse.
- `io_rdata` out 32: instruction word; qualified by `io_respValid`.
- `io_respErr` out 1: response is an access fault; qualified by `io_respValid`.
- `load_en` in 1: backdoor write strobe.
- `load_addr` in $clog2(DEPTH_WORDS): word index for backdoor write.
- `load_data` in 32: backdoor write data.

## Operation
- States: IDLE, BUSY, RESP. Reset → IDLE, counter = 0, latched index/err = 0.
- Reset values: `io_respValid`=0, `io_rdata`=0, `io_respErr`=0. Array contents are not reset.
- IDLE: if `io_reqValid`=1, accept. Latch index = (`io_addr`−`BASE_ADDR`)>>2 and err. Go to RESP if `LATENCY`=1; otherwise go to BUSY with counter = `LATENCY`−2.
- err = 1 if `io_addr[1:0]`≠0, `io_addr`<`BASE_ADDR`, or `io_addr`−`BASE_ADDR` ≥ `DEPTH_WORDS*4`. Compare in 33-bit arithmetic so there is no wrap-around.
- BUSY: if counter = 0, go to RESP; else decrement the counter. `io_reqValid` is ignored in BUSY, with no queuing.
- RESP: `io_respValid`=1.
  - `io_rdata` = array[index] if err=0; `io_rdata` = 32'h0000_0000 with `io_respErr`=1 if err=1.
  - Next state is IDLE, except in the back-to-back case under Configuration.
- Outside RESP, `io_rdata`=0 and `io_respErr`=0.
- Backdoor: when `load_en`=1, array[`load_addr`] ← `load_data` at the clock edge. This happens in any state.
- Load and read of the same index in the RESP cycle: the read returns the old data (read-before-write).
- Asserting `reset_n`=0 mid-transaction aborts the transaction immediately. No response is issued for it, and the array is preserved.

## Timing
- Acceptance at edge T (IDLE, `io_reqValid` sampled 1): `io_respValid` is high for the cycle following edge T+`LATENCY`−1. That is, the response is sampled by the requester at edge T+`LATENCY`.
- Exactly one `io_respValid` pulse per accepted request. Never two consecutive high cycles unless back-to-back is enabled.
- Minimum request-to-request spacing without back-to-back: `LATENCY`+1 cycles.
- `io_rdata` and `io_respErr` are driven combinationally from registered state and the array. There is no path from `io_addr` to any output.

## Configuration
- `IMEM_BACK2BACK_EN` defined:
  - In RESP, an `io_reqValid`=1 is accepted in the same cycle as the response. The address and err are latched and the counter is loaded exactly as from IDLE.
  - With `LATENCY`=1, this gives one response per cycle.
- `IMEM_BACK2BACK_EN` undefined: `io_reqValid` in RESP is ignored and the state returns to IDLE. The requester must hold or re-present the request in IDLE.

## Test plan
- Latency 2, preload word 0 = 32'h0000_0013; request 32'h8000_0000 at edge T → `io_respValid`=1 only in the cycle sampled at T+2, `io_rdata`=32'h0000_0013, `io_respErr`=0.
- Misaligned 32'h8000_0002, and out-of-range 32'h8000_1000 with depth 1024 → response with `io_rdata`=0, `io_respErr`=1, same latency.
- `io_reqValid` held high continuously, latency 3, no back-to-back → responses exactly every 4 cycles, data tracking the latched addresses.
- With `IMEM_BACK2BACK_EN`, latency 1, addresses 8000_0000/04/08 on consecutive cycles → three consecutive response cycles in order.
- Backdoor write of index 5 = 32'hDEAD_BEEF in the RESP cycle of a read of index 5 (old value 32'h1) → returns 32'h1; the next read returns 32'hDEAD_BEEF.
- `reset_n` pulsed low while in BUSY → no `io_respValid`, outputs 0, next request served normally with array contents intact.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch-side IO port.
// Accepts one outstanding word read, waits LATENCY cycles, then pulses io_respValid
// for one cycle with the instruction word or an access fault.
// A backdoor write port preloads the word array.
// Optional feature macro: IMEM_BACK2BACK_EN. When it is defined, a new request can
// be accepted in the same cycle as a response.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           io_reqValid,
  input  logic [31:0]                    io_addr,
  output logic                           io_respValid,
  output logic [31:0]                    io_rdata,
  output logic                           io_respErr,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CntLoad = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  // 33-bit window bounds so an address near the top of the space cannot wrap.
  localparam logic [32:0] AddrLo = {1'b0, BASE_ADDR};
  localparam logic [32:0] AddrHi = AddrLo + (33'(DEPTH_WORDS) << 2);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic           err_q, err_d;
  logic [31:0]    mem_q [DEPTH_WORDS];

  logic           accept;
  logic           req_err;
  logic [32:0]    addr_ext;

  // Decode the incoming address: fault on misalignment or outside the window.
  always_comb begin
    addr_ext = {1'b0, io_addr};
    req_err  = (io_addr[1:0] != 2'b00) || (addr_ext < AddrLo) || (addr_ext >= AddrHi);
`ifdef IMEM_BACK2BACK_EN
    accept   = io_reqValid && ((state_q == StIdle) || (state_q == StResp));
`else
    accept   = io_reqValid && (state_q == StIdle);
`endif
  end

  // State register: counter and latched request; cleared on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: count down the latency, then one response cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: state_d = StIdle;
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (accept) begin
      // BASE_ADDR is aligned to the array size, so the low address bits are the index.
      idx_d = io_addr[AW+1:2];
      err_d = req_err;
      if (LATENCY == 1) begin
        state_d = StResp;
        cnt_d   = 4'd0;
      end else begin
        state_d = StBusy;
        cnt_d   = CntLoad;
      end
    end
  end

  // Outputs depend only on registered state and the array contents.
  always_comb begin
    io_respValid = (state_q == StResp);
    io_respErr   = io_respValid && err_q;
    io_rdata     = (io_respValid && !err_q) ? mem_q[idx_q] : 32'h0000_0000;
  end

  // Backdoor write. The read above is combinational from the current contents,
  // so a write to the same index in the response cycle returns the old word.
  always_ff @(posedge clock) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: LATENCY=2 vector table, a held request
// at LATENCY=3, and LATENCY=1 response spacing (IMEM_BACK2BACK_EN selects expectations).
module tb_imem_responder;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // LATENCY = 2 instance
  logic r2_req = 1'b0; logic [31:0] r2_addr = '0; logic r2_v; logic [31:0] r2_data; logic r2_err;
  logic r2_len = 1'b0; logic [9:0] r2_lad = '0; logic [31:0] r2_ldat = '0;
  // LATENCY = 3 instance
  logic r3_req = 1'b0; logic [31:0] r3_addr = '0; logic r3_v; logic [31:0] r3_data; logic r3_err;
  logic r3_len = 1'b0; logic [9:0] r3_lad = '0; logic [31:0] r3_ldat = '0;
  // LATENCY = 1 instance
  logic r1_req = 1'b0; logic [31:0] r1_addr = '0; logic r1_v; logic [31:0] r1_data; logic r1_err;
  logic r1_len = 1'b0; logic [9:0] r1_lad = '0; logic [31:0] r1_ldat = '0;

  imem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h8000_0000)) u_l2 (
    .clock(clock), .reset_n(reset_n), .io_reqValid(r2_req), .io_addr(r2_addr),
    .io_respValid(r2_v), .io_rdata(r2_data), .io_respErr(r2_err),
    .load_en(r2_len), .load_addr(r2_lad), .load_data(r2_ldat)
  );
  imem_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .BASE_ADDR(32'h8000_0000)) u_l3 (
    .clock(clock), .reset_n(reset_n), .io_reqValid(r3_req), .io_addr(r3_addr),
    .io_respValid(r3_v), .io_rdata(r3_data), .io_respErr(r3_err),
    .load_en(r3_len), .load_addr(r3_lad), .load_data(r3_ldat)
  );
  imem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h8000_0000)) u_l1 (
    .clock(clock), .reset_n(reset_n), .io_reqValid(r1_req), .io_addr(r1_addr),
    .io_respValid(r1_v), .io_rdata(r1_data), .io_respErr(r1_err),
    .load_en(r1_len), .load_addr(r1_lad), .load_data(r1_ldat)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic load(input int d, input logic [9:0] idx, input logic [31:0] data);
    @(negedge clock);
    case (d)
      1: begin r1_len = 1'b1; r1_lad = idx; r1_ldat = data; end
      2: begin r2_len = 1'b1; r2_lad = idx; r2_ldat = data; end
      default: begin r3_len = 1'b1; r3_lad = idx; r3_ldat = data; end
    endcase
    @(negedge clock);
    r1_len = 1'b0; r2_len = 1'b0; r3_len = 1'b0;
  endtask

  // One request on the LATENCY=2 instance; address is changed right after acceptance.
  task automatic req2(input string name, input logic [31:0] addr, input logic [31:0] exp_d,
                      input logic exp_e);
    @(negedge clock);
    r2_req = 1'b1; r2_addr = addr;
    @(negedge clock);
    chk({name, " busy valid"}, {31'b0, r2_v}, 32'd0);
    chk({name, " busy rdata"}, r2_data, 32'd0);
    r2_req = 1'b0; r2_addr = 32'h8000_0008;
    @(negedge clock);
    chk({name, " resp valid"}, {31'b0, r2_v}, 32'd1);
    chk({name, " resp rdata"}, r2_data, exp_d);
    chk({name, " resp err"}, {31'b0, r2_err}, {31'b0, exp_e});
    @(negedge clock);
    chk({name, " after valid"}, {31'b0, r2_v}, 32'd0);
    chk({name, " after err"}, {31'b0, r2_err}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a_words[3];
    logic [31:0] b_words[3];
    logic        exp_v1[5];
    logic [31:0] exp_d1[5];

    a_words[0] = 32'hA0A0_A0A0; a_words[1] = 32'hA1A1_A1A1; a_words[2] = 32'hA2A2_A2A2;
    b_words[0] = 32'hB0B0_B0B0; b_words[1] = 32'hB1B1_B1B1; b_words[2] = 32'hB2B2_B2B2;

    vecs[0] = '{32'h8000_0000, 32'h0000_0013, 1'b0};
    vecs[1] = '{32'h8000_0004, 32'h1111_1111, 1'b0};
    vecs[2] = '{32'h8000_0FFC, 32'hCAFE_F00D, 1'b0};
    vecs[3] = '{32'h8000_0002, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h8000_1000, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h7FFF_FFFC, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
    vecs[7] = '{32'h8000_0001, 32'h0000_0000, 1'b1};

`ifdef IMEM_BACK2BACK_EN
    exp_v1 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d1 = '{32'h0, b_words[0], b_words[1], b_words[2], 32'h0};
`else
    exp_v1 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_d1 = '{32'h0, b_words[0], 32'h0, b_words[2], 32'h0};
`endif

    // Reset state
    repeat (2) @(negedge clock);
    chk("reset valid", {31'b0, r2_v}, 32'd0);
    chk("reset rdata", r2_data, 32'd0);
    chk("reset err", {31'b0, r2_err}, 32'd0);
    reset_n = 1'b1;

    load(2, 10'd0, 32'h0000_0013);
    load(2, 10'd1, 32'h1111_1111);
    load(2, 10'd2, 32'h2222_2222);
    load(2, 10'd5, 32'h0000_0001);
    load(2, 10'd1023, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      load(3, 10'(i), a_words[i]);
      load(1, 10'(i), b_words[i]);
    end

    // Vector table on LATENCY=2
    for (int i = 0; i < 8; i++) begin
      req2($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].err);
    end

    // Backdoor write of index 5 during the response cycle of a read of index 5
    @(negedge clock);
    r2_req = 1'b1; r2_addr = 32'h8000_0014;
    @(negedge clock);
    r2_req = 1'b0;
    @(posedge clock);
    #1;
    r2_len = 1'b1; r2_lad = 10'd5; r2_ldat = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("rbw valid", {31'b0, r2_v}, 32'd1);
    chk("rbw old data", r2_data, 32'h0000_0001);
    @(posedge clock);
    #1;
    r2_len = 1'b0;
    req2("rbw new", 32'h8000_0014, 32'hDEAD_BEEF, 1'b0);

    // Reset while BUSY aborts the transaction, array kept
    @(negedge clock);
    r2_req = 1'b1; r2_addr = 32'h8000_0004;
    @(negedge clock);
    r2_req = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst busy valid", {31'b0, r2_v}, 32'd0);
    @(negedge clock);
    chk("rst low valid", {31'b0, r2_v}, 32'd0);
    chk("rst low rdata", r2_data, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst after valid1", {31'b0, r2_v}, 32'd0);
    @(negedge clock);
    chk("rst after valid2", {31'b0, r2_v}, 32'd0);
    req2("post reset", 32'h8000_0004, 32'h1111_1111, 1'b0);

    // Held request on LATENCY=3: one response every 4 cycles
    @(negedge clock);
    r3_req = 1'b1; r3_addr = 32'h8000_0000;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      chk($sformatf("held valid k%0d", k), {31'b0, r3_v}, {31'b0, (k % 4) == 3});
      if ((k % 4) == 3) begin
        chk($sformatf("held rdata k%0d", k), r3_data, a_words[((k - 3) / 4) % 3]);
      end else begin
        chk($sformatf("held idle rdata k%0d", k), r3_data, 32'd0);
      end
      r3_addr = 32'h8000_0000 + 32'(4 * (k % 3));
    end
    r3_req = 1'b0;
    repeat (4) @(negedge clock);

    // LATENCY=1 consecutive requests
    r1_req = 1'b1; r1_addr = 32'h8000_0000;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      chk($sformatf("l1 valid k%0d", k), {31'b0, r1_v}, {31'b0, exp_v1[k]});
      chk($sformatf("l1 rdata k%0d", k), r1_data, exp_d1[k]);
      if (k <= 2) begin
        r1_addr = 32'h8000_0000 + 32'(4 * k);
      end else begin
        r1_req = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
